m4_im_copy_seq: RTL and testbench

//  Sequences a multi-page copy from M4 correction SRAM to the IM EEPROM. Drives the SRAM read

---
 rtl/m4_im_copy_seq_pkg.sv | 37 +++
 rtl/m4_im_copy_seq_if.sv | 41 ++++
 rtl/m4_im_seq_wdog.sv | 42 ++++
 rtl/m4_im_copy_seq.sv | 238 +++++++++++++++++++++++
 tb/tb_m4_im_copy_seq.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/m4_im_copy_seq_pkg.sv
// Shared definitions for the M4 -> IM copy sequencer: state encoding, page width, defaults.
// The ERR state exists only when M4_IMSEQ_TIMEOUT_EN is defined.
package m4_im_pkg;

    localparam int PAGE_W          = 11;
    localparam int WE_PER_PAGE_DEF = 31;
    localparam int WE_CNT_W        = 6;

`ifdef M4_IMSEQ_TIMEOUT_EN
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ARM  = 3'd1,
        ST_STRB = 3'd2,
        ST_FILL = 3'd3,
        ST_PROG = 3'd4,
        ST_EEWT = 3'd5,
        ST_FIN  = 3'd6,
        ST_ERR  = 3'd7
    } state_e;
`else
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ARM  = 3'd1,
        ST_STRB = 3'd2,
        ST_FILL = 3'd3,
        ST_PROG = 3'd4,
        ST_EEWT = 3'd5,
        ST_FIN  = 3'd6
    } state_e;
`endif

    // Page numbers are 11-bit and wrap 2047 -> 0 by design.
    function automatic logic [PAGE_W-1:0] next_page(input logic [PAGE_W-1:0] page);
        return page + 11'd1;
    endfunction

endpackage

// File: rtl/m4_im_copy_seq_if.sv
// Command/handshake bundle between the copy sequencer (master) and its environment (slave):
// host decoder, SRAM reader and EEPROM programmer.
interface m4_im_copy_seq_if;
    import m4_im_pkg::*;

    logic              start;
    logic              abort;
    logic [PAGE_W-1:0] page_first;
    logic [PAGE_W-1:0] page_cnt;
    logic [3:0]        ope_vadrs;
    logic [3:0]        ope_hadrs;
    logic              m4_cmd_cycle_stp;
    logic              rd_weo;
    logic              ee_ack;
    logic              ee_busy;

    logic              copy_to_im;
    logic              im_ram_rstr;
    logic [PAGE_W-1:0] im_32byte_num;
    logic [3:0]        im_ope_vadrs;
    logic [3:0]        im_ope_hadrs;
    logic              ee_req;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        input  start, abort, page_first, page_cnt, ope_vadrs, ope_hadrs,
               m4_cmd_cycle_stp, rd_weo, ee_ack, ee_busy,
        output copy_to_im, im_ram_rstr, im_32byte_num, im_ope_vadrs, im_ope_hadrs,
               ee_req, busy, done, err
    );

    modport slave (
        output start, abort, page_first, page_cnt, ope_vadrs, ope_hadrs,
               m4_cmd_cycle_stp, rd_weo, ee_ack, ee_busy,
        input  copy_to_im, im_ram_rstr, im_32byte_num, im_ope_vadrs, im_ope_hadrs,
               ee_req, busy, done, err
    );

endinterface

// File: rtl/m4_im_seq_wdog.sv
// Watchdog for the copy sequencer: reloads to all-ones, counts down while enabled, and
// flags expiry once a full all-ones span of cycles has elapsed since the last reload.
module m4_im_seq_wdog #(
    parameter int TMO_W = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic expired
);

    logic [TMO_W-1:0] cnt_q, cnt_d;
    logic             exp_q, exp_d;

    // Next-count and expiry computation.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = {TMO_W{1'b1}};
        end else if (en && (cnt_q != {TMO_W{1'b0}})) begin
            cnt_d = cnt_q - {{(TMO_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
        exp_d = !load && (cnt_d == {TMO_W{1'b0}});
    end

    // Counter and expiry flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= {TMO_W{1'b0}};
            exp_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            exp_q <= exp_d;
        end
    end

    assign expired = exp_q;

endmodule

// File: rtl/m4_im_copy_seq.sv
// Multi-page copy sequencer from M4 correction SRAM to IM EEPROM.
// Optional watchdog and ERR state are built when M4_IMSEQ_TIMEOUT_EN is defined.
module m4_im_copy_seq
    import m4_im_pkg::*;
#(
    parameter int WE_PER_PAGE = WE_PER_PAGE_DEF,
    parameter int TMO_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    m4_im_copy_seq_if.master bus
);

    localparam logic [WE_CNT_W-1:0] WE_LAST = WE_CNT_W'(WE_PER_PAGE - 1);

    state_e              state_q, state_d;
    logic                copy_q, copy_d;
    logic                rstr_q, rstr_d;
    logic                req_q, req_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [PAGE_W-1:0]   page_q, page_d;
    logic [PAGE_W-1:0]   left_q, left_d;
    logic [3:0]          vadrs_q, vadrs_d;
    logic [3:0]          hadrs_q, hadrs_d;
    logic [WE_CNT_W-1:0] we_cnt_q, we_cnt_d;
    logic                strb_q, strb_d;
    logic                seen_q, seen_d;

`ifdef M4_IMSEQ_TIMEOUT_EN
    logic err_q, err_d;
    logic wdog_exp_s;
    logic wdog_load_s;
    logic wdog_en_s;

    assign wdog_load_s = (state_d != state_q);
    assign wdog_en_s   = (state_q == ST_FILL) || (state_q == ST_PROG) || (state_q == ST_EEWT);

    m4_im_seq_wdog #(.TMO_W(TMO_W)) u_wdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (wdog_load_s),
        .en      (wdog_en_s),
        .expired (wdog_exp_s)
    );
`endif

    // Next-state and next-output logic; abort overrides everything, including a start.
    always_comb begin
        state_d  = state_q;
        copy_d   = copy_q;
        rstr_d   = rstr_q;
        req_d    = req_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        page_d   = page_q;
        left_d   = left_q;
        vadrs_d  = vadrs_q;
        hadrs_d  = hadrs_q;
        we_cnt_d = we_cnt_q;
        strb_d   = strb_q;
        seen_d   = seen_q;
`ifdef M4_IMSEQ_TIMEOUT_EN
        err_d    = err_q;
`endif
        if (bus.abort) begin
            state_d = ST_IDLE;
            copy_d  = 1'b0;
            rstr_d  = 1'b0;
            req_d   = 1'b0;
            busy_d  = 1'b0;
        end
`ifdef M4_IMSEQ_TIMEOUT_EN
        else if (wdog_exp_s && wdog_en_s) begin
            state_d = ST_ERR;
            err_d   = 1'b1;
            copy_d  = 1'b0;
            rstr_d  = 1'b0;
            req_d   = 1'b0;
        end
`endif
        else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start && (bus.page_cnt != 11'd0)) begin
                        state_d = ST_ARM;
                        page_d  = bus.page_first;
                        left_d  = bus.page_cnt;
                        vadrs_d = bus.ope_vadrs;
                        hadrs_d = bus.ope_hadrs;
                        copy_d  = 1'b1;
                        busy_d  = 1'b1;
`ifdef M4_IMSEQ_TIMEOUT_EN
                        err_d   = 1'b0;
`endif
                    end else if (bus.start) begin
                        done_d = 1'b1;
                    end else begin
                        busy_d = 1'b0;
                    end
                end
                ST_ARM: begin
                    if (bus.m4_cmd_cycle_stp) begin
                        state_d  = ST_STRB;
                        rstr_d   = 1'b1;
                        strb_d   = 1'b0;
                        we_cnt_d = {WE_CNT_W{1'b0}};
                    end else begin
                        state_d = ST_ARM;
                    end
                end
                ST_STRB: begin
                    // Read strobe spans exactly two cycles: entry cycle plus one more.
                    if (strb_q) begin
                        state_d = ST_FILL;
                        rstr_d  = 1'b0;
                    end else begin
                        strb_d = 1'b1;
                    end
                end
                ST_FILL: begin
                    if (bus.rd_weo && (we_cnt_q == WE_LAST)) begin
                        state_d  = ST_PROG;
                        req_d    = 1'b1;
                        we_cnt_d = we_cnt_q + 6'd1;
                    end else if (bus.rd_weo) begin
                        we_cnt_d = we_cnt_q + 6'd1;
                    end else begin
                        we_cnt_d = we_cnt_q;
                    end
                end
                ST_PROG: begin
                    if (bus.ee_ack) begin
                        state_d = ST_EEWT;
                        req_d   = 1'b0;
                        seen_d  = 1'b0;
                    end else begin
                        req_d = 1'b1;
                    end
                end
                ST_EEWT: begin
                    // Busy must be observed high before its fall counts as page completion.
                    if (!seen_q) begin
                        seen_d = bus.ee_busy;
                    end else if (bus.ee_busy) begin
                        seen_d = 1'b1;
                    end else if (left_q == 11'd1) begin
                        state_d = ST_FIN;
                        left_d  = 11'd0;
                        copy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_ARM;
                        left_d  = left_q - 11'd1;
                        page_d  = next_page(page_q);
                    end
                end
                ST_FIN: begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
`ifdef M4_IMSEQ_TIMEOUT_EN
                ST_ERR: begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
`endif
                default: begin
                    state_d = ST_IDLE;
                    copy_d  = 1'b0;
                    rstr_d  = 1'b0;
                    req_d   = 1'b0;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    // State, counter and registered-output flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            copy_q   <= 1'b0;
            rstr_q   <= 1'b0;
            req_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            page_q   <= 11'd0;
            left_q   <= 11'd0;
            vadrs_q  <= 4'd0;
            hadrs_q  <= 4'd0;
            we_cnt_q <= 6'd0;
            strb_q   <= 1'b0;
            seen_q   <= 1'b0;
`ifdef M4_IMSEQ_TIMEOUT_EN
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            copy_q   <= copy_d;
            rstr_q   <= rstr_d;
            req_q    <= req_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            page_q   <= page_d;
            left_q   <= left_d;
            vadrs_q  <= vadrs_d;
            hadrs_q  <= hadrs_d;
            we_cnt_q <= we_cnt_d;
            strb_q   <= strb_d;
            seen_q   <= seen_d;
`ifdef M4_IMSEQ_TIMEOUT_EN
            err_q    <= err_d;
`endif
        end
    end

    assign bus.copy_to_im    = copy_q;
    assign bus.im_ram_rstr   = rstr_q;
    assign bus.im_32byte_num = page_q;
    assign bus.im_ope_vadrs  = vadrs_q;
    assign bus.im_ope_hadrs  = hadrs_q;
    assign bus.ee_req        = req_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;

`ifdef M4_IMSEQ_TIMEOUT_EN
    assign bus.err = err_q;
`else
    // Without the watchdog there is no error source; TMO_W only sizes the optional counter.
    if (TMO_W > 0) begin : g_err_tie
        assign bus.err = 1'b0;
    end else begin : g_err_tie_zw
        assign bus.err = 1'b0;
    end
`endif

endmodule

// File: tb/tb_m4_im_copy_seq.sv
// Directed/randomized bench for m4_im_copy_seq; expected page sequences, request and done
// counts come from per-job arithmetic (first + i mod 2048, one request per page, one done).
module tb_m4_im_copy_seq;
    import m4_im_pkg::*;

`ifdef M4_IMSEQ_TIMEOUT_EN
    localparam int TB_TMO_W = 8;
`else
    localparam int TB_TMO_W = 16;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int total = 0;
    int bad   = 0;

    int   req_rises = 0;
    int   done_cnt  = 0;
    int   copy_cyc  = 0;
    int   rstr_cyc  = 0;
    logic req_prev  = 1'b0;

    m4_im_copy_seq_if bus ();

    m4_im_copy_seq #(.WE_PER_PAGE(31), .TMO_W(TB_TMO_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Event counters; values seen at a rising edge are the settled outputs of the prior cycle.
    always @(posedge clk) begin
        req_prev <= bus.ee_req;
        if (bus.ee_req && !req_prev) req_rises <= req_rises + 1;
        if (bus.done)        done_cnt <= done_cnt + 1;
        if (bus.copy_to_im)  copy_cyc <= copy_cyc + 1;
        if (bus.im_ram_rstr) rstr_cyc <= rstr_cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_copy"}, 32'(bus.copy_to_im), 32'd0);
        chk({tag, "_rstr"}, 32'(bus.im_ram_rstr), 32'd0);
        chk({tag, "_page"}, 32'(bus.im_32byte_num), 32'd0);
        chk({tag, "_vadr"}, 32'(bus.im_ope_vadrs), 32'd0);
        chk({tag, "_hadr"}, 32'(bus.im_ope_hadrs), 32'd0);
        chk({tag, "_req"},  32'(bus.ee_req), 32'd0);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, "_done"}, 32'(bus.done), 32'd0);
        chk({tag, "_err"},  32'(bus.err), 32'd0);
    endtask

    task automatic start_job(input int first, input int cnt, input int vad, input int had);
        bus.page_first = 11'(first);
        bus.page_cnt   = 11'(cnt);
        bus.ope_vadrs  = 4'(vad);
        bus.ope_hadrs  = 4'(had);
        bus.start      = 1'b1;
        cyc(1);
        bus.start      = 1'b0;
    endtask

    // Strobe the command slot and check the two-cycle read strobe; ends in FILL.
    task automatic strobe_page(input int exp_page);
        cyc($urandom_range(0, 3));
        bus.m4_cmd_cycle_stp = 1'b1;
        cyc(1);
        bus.m4_cmd_cycle_stp = 1'b0;
        chk("rstr_on", 32'(bus.im_ram_rstr), 32'd1);
        chk("page_num", 32'(bus.im_32byte_num), 32'(exp_page));
        cyc(1);
        chk("rstr_hold", 32'(bus.im_ram_rstr), 32'd1);
        cyc(1);
        chk("rstr_off", 32'(bus.im_ram_rstr), 32'd0);
    endtask

    // n write strobes with random gaps; optionally a stray start mid-page.
    task automatic send_weo(input int n, input bit poke);
        for (int k = 0; k < n; k++) begin
            cyc($urandom_range(0, 2));
            if (poke && k == 3) begin
                bus.page_first = 11'($urandom_range(0, 2047));
                bus.page_cnt   = 11'($urandom_range(0, 2047));
                bus.start      = 1'b1;
                cyc(1);
                bus.start      = 1'b0;
            end
            if (k == 30) chk("req_early", 32'(bus.ee_req), 32'd0);
            bus.rd_weo = 1'b1;
            cyc(1);
            bus.rd_weo = 1'b0;
        end
    endtask

    task automatic do_page(input int exp_page, input bit last);
        strobe_page(exp_page);
        send_weo(31, 1'b1);
        chk("req_on", 32'(bus.ee_req), 32'd1);
        bus.rd_weo = 1'b1;
        cyc(1);
        bus.rd_weo = 1'b0;
        cyc($urandom_range(0, 2));
        chk("req_hold", 32'(bus.ee_req), 32'd1);
        bus.ee_ack = 1'b1;
        cyc(1);
        bus.ee_ack  = 1'b0;
        bus.ee_busy = 1'b1;
        chk("req_off", 32'(bus.ee_req), 32'd0);
        chk("copy_prog", 32'(bus.copy_to_im), 32'd1);
        cyc($urandom_range(1, 3));
        bus.ee_busy = 1'b0;
        cyc(1);
        if (last) begin
            chk("done_pulse", 32'(bus.done), 32'd1);
            chk("copy_fin", 32'(bus.copy_to_im), 32'd0);
            cyc(1);
            chk("done_gone", 32'(bus.done), 32'd0);
            chk("busy_end", 32'(bus.busy), 32'd0);
        end else begin
            chk("copy_next", 32'(bus.copy_to_im), 32'd1);
            chk("busy_next", 32'(bus.busy), 32'd1);
        end
    endtask

    task automatic run_job(input int first, input int cnt);
        int base_req;
        int base_done;
        int vad;
        int had;
        vad       = $urandom_range(0, 15);
        had       = $urandom_range(0, 15);
        base_req  = req_rises;
        base_done = done_cnt;
        start_job(first, cnt, vad, had);
        chk("copy_arm", 32'(bus.copy_to_im), 32'd1);
        chk("busy_arm", 32'(bus.busy), 32'd1);
        chk("vadrs", 32'(bus.im_ope_vadrs), 32'(vad));
        chk("hadrs", 32'(bus.im_ope_hadrs), 32'(had));
        for (int i = 0; i < cnt; i++) begin
            do_page((first + i) % 2048, i == cnt - 1);
        end
        cyc(2);
        chk("req_count", 32'(req_rises - base_req), 32'(cnt));
        chk("done_count", 32'(done_cnt - base_done), 32'd1);
        chk("err_clear", 32'(bus.err), 32'd0);
    endtask

    initial begin
        int base_done;
        int base_req;
        int base_copy;
        int base_rstr;
        bus.start = 1'b0; bus.abort = 1'b0; bus.page_first = 11'd0; bus.page_cnt = 11'd0;
        bus.ope_vadrs = 4'd0; bus.ope_hadrs = 4'd0; bus.m4_cmd_cycle_stp = 1'b0;
        bus.rd_weo = 1'b0; bus.ee_ack = 1'b0; bus.ee_busy = 1'b0;

        #3;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1);
        check_all_zero("post_reset");

        run_job(5, 3);

        // Zero-page command: done only, no copy activity.
        base_done = done_cnt; base_copy = copy_cyc; base_rstr = rstr_cyc;
        start_job(77, 0, 1, 2);
        chk("zero_done", 32'(bus.done), 32'd1);
        chk("zero_busy", 32'(bus.busy), 32'd0);
        cyc(1);
        chk("zero_done_gone", 32'(bus.done), 32'd0);
        cyc(2);
        chk("zero_done_cnt", 32'(done_cnt - base_done), 32'd1);
        chk("zero_copy_cnt", 32'(copy_cyc - base_copy), 32'd0);
        chk("zero_rstr_cnt", 32'(rstr_cyc - base_rstr), 32'd0);

        run_job(2047, 2);

        for (int j = 0; j < 2; j++) begin
            run_job($urandom_range(0, 2047), $urandom_range(1, 3));
        end

        // Abort in FILL after ten strobes.
        base_done = done_cnt; base_req = req_rises;
        start_job(300, 2, 3, 4);
        strobe_page(300);
        send_weo(10, 1'b0);
        bus.abort = 1'b1;
        cyc(1);
        bus.abort = 1'b0;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_copy", 32'(bus.copy_to_im), 32'd0);
        chk("abort_req", 32'(bus.ee_req), 32'd0);
        chk("abort_rstr", 32'(bus.im_ram_rstr), 32'd0);
        cyc(3);
        chk("abort_no_done", 32'(done_cnt - base_done), 32'd0);
        chk("abort_no_req", 32'(req_rises - base_req), 32'd0);

        // Abort and start together in IDLE.
        base_done = done_cnt;
        bus.page_cnt = 11'd2; bus.start = 1'b1; bus.abort = 1'b1;
        cyc(1);
        bus.start = 1'b0; bus.abort = 1'b0;
        chk("abst_busy", 32'(bus.busy), 32'd0);
        chk("abst_copy", 32'(bus.copy_to_im), 32'd0);
        cyc(2);
        chk("abst_no_done", 32'(done_cnt - base_done), 32'd0);

        // Asynchronous reset while a page waits for programming.
        start_job(1000, 2, 5, 6);
        strobe_page(1000);
        send_weo(31, 1'b0);
        chk("prog_req", 32'(bus.ee_req), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1);
        run_job(10, 1);

`ifdef M4_IMSEQ_TIMEOUT_EN
        begin
            int n;
            start_job(40, 1, 7, 8);
            strobe_page(40);
            send_weo(31, 1'b0);
            bus.ee_ack = 1'b1;
            cyc(1);
            bus.ee_ack  = 1'b0;
            bus.ee_busy = 1'b1;
            n = 0;
            while (!bus.err && n < 300) begin
                cyc(1);
                n++;
            end
            chk("wdog_err", 32'(bus.err), 32'd1);
            chk("wdog_in_time", 32'(n <= 256), 32'd1);
            chk("wdog_copy", 32'(bus.copy_to_im), 32'd0);
            chk("wdog_req", 32'(bus.ee_req), 32'd0);
            cyc(1);
            chk("wdog_idle", 32'(bus.busy), 32'd0);
            chk("wdog_err_sticky", 32'(bus.err), 32'd1);
            bus.ee_busy = 1'b0;
            cyc(2);
            run_job(50, 1);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time limit so the run always terminates.
    initial begin
        #2000000;
        bad++;
        $display("FAIL timeout: observed=running expected=finished");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "simulation time limit");
    end

endmodule
